pcm_sample_buffer: RTL and testbench
====================================

// Module: pcm_sample_buffer
// PURPOSE
//  Elastic buffer between music_player and the ac97_if codec. Music_player pushes
//  16-bit signed samples on new_sample_generated. The codec pulls one sample per
//  PCM_Playback_Accept (new_frame) pulse. Adds priming, underrun handling,
//  overflow reporting, mute and power-of-two volume attenuation.
// PARAMETERS
//  DEPTH        16  FIFO entries; power of two, >=4
//  PRIME_LEVEL  8   entries required before playback (re)starts; 1..DEPTH
//  CNT_W        16  width of the saturating underrun counter
// PORTS
//  clk             in   1            system clock
//  reset           in   1            asynchronous, active-high
//  sample_valid    in   1            push strobe (music_player new_sample_generated)
//  sample_in       in   16           signed PCM sample to push
//  sample_ready    out  1            1 = FIFO not full
//  new_frame       in   1            1-cycle codec pull pulse (PCM_Playback_Accept)
//  mute            in   1            1 = emit silence; FIFO still pops
//  vol_shift       in   3            arithmetic right-shift amount, 0..7
//  pcm_out         out  16           signed sample to codec, held between frames
//  fifo_level      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  underrun        out  1            1-cycle pulse: RUN-state frame found FIFO empty
//  overflow        out  1            1-cycle pulse: push dropped because FIFO full
//  underrun_count  out  CNT_W        saturating count of underrun pulses
// BEHAVIOUR
//  Reset (async assert, sync use on release):
//   - pcm_out=0, fifo_level=0, sample_ready=1, underrun=0, overflow=0, underrun_count=0.
//   - Pointers cleared, state=PRIME.
//  Push:
//   - Accept when sample_valid && (!full || new_frame pops this cycle).
//   - On full with no pop: sample dropped, overflow pulses next cycle, FIFO unchanged.
//  FSM:
//   - PRIME: new_frame -> pcm_out<=0, no pop, no underrun. Go to RUN when
//     fifo_level>=PRIME_LEVEL (evaluated on registered level).
//   - RUN: new_frame && !empty -> pop. pcm_out<=mute?0:(head>>>vol_shift), sign-extended.
//     new_frame && empty -> pcm_out<=0, underrun pulse, count+1 (saturate at all-ones),
//     state->PRIME.
//  Latency:
//   - pcm_out changes the cycle after new_frame; held until the next new_frame.
//   - A push into an empty FIFO is poppable one cycle later; no same-cycle bypass.
//     Push and new_frame together on empty in RUN = underrun, and the push is stored.
//  Level/flags:
//   - fifo_level updates +1/-1/0 per cycle (push+pop together = 0).
//   - sample_ready=(fifo_level!=DEPTH).
//  Wrap-around: pointers are $clog2(DEPTH)+1 bits. full/empty come from MSB compare.
//  mute and vol_shift are sampled only at the pop cycle; changes between frames
//   do not alter the held pcm_out.
//  Reset mid-operation: contents discarded; returns to PRIME with all outputs at reset values.
// STRUCTURE
//  audio_pkg: SAMPLE_W=16, buffer state encoding (PRIME=0, RUN=1),
//   shared with music_player.
//  Sub-module sync_fifo (DEPTH, WIDTH): registered storage, pointers, level,
//   full/empty. Top level holds the FSM, scaling, pulses and counter.
// TESTING
//  1 Reset, then 20 idle frames -> pcm_out=0, underrun never pulses, state PRIME.
//  2 Push 8 samples 100..800, then 8 frames with vol_shift=0 -> pcm_out 100,200..800
//    in order, each one cycle after its frame.
//  3 Then a 9th frame with FIFO empty -> pcm_out=0, underrun 1 cycle,
//    underrun_count=1, back to PRIME.
//  4 Push 17 samples with no frames, DEPTH=16 -> fifo_level=16, sample_ready=0,
//    overflow pulses once, 17th sample never appears.
//  5 Push -1024 with vol_shift=3 -> pcm_out=-128. Same with mute=1 -> 0, level still -1.
//  6 Full FIFO, push+new_frame same cycle -> push accepted, level stays 16.
//    Reset asserted mid-stream -> level=0 and pcm_out=0 immediately.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample width, buffer state encoding and scaling helper
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic {
        BUF_PRIME = 1'b0,
        BUF_RUN   = 1'b1
    } buf_state_t;

    // Mute forces silence; otherwise an arithmetic shift keeps the sign.
    function automatic logic signed [SAMPLE_W-1:0] scale_sample(
        input logic signed [SAMPLE_W-1:0] s,
        input logic [2:0]                 shift,
        input logic                       mute
    );
        if (mute) begin
            return '0;
        end
        return s >>> shift;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers, registered level and full/empty
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Same index with differing wrap bit means the writer lapped the reader.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pcm_sample_buffer.sv
// rtl/pcm_sample_buffer.sv - elastic PCM buffer with priming, underrun/overflow reporting, mute and volume
module pcm_sample_buffer
    import audio_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 8,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_valid,
    input  logic signed [SAMPLE_W-1:0]  sample_in,
    output logic                        sample_ready,
    input  logic                        new_frame,
    input  logic                        mute,
    input  logic [2:0]                  vol_shift,
    output logic signed [SAMPLE_W-1:0]  pcm_out,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic                        underrun,
    output logic                        overflow,
    output logic [CNT_W-1:0]            underrun_count
);

    localparam int LW = $clog2(DEPTH) + 1;

    buf_state_t                 state;
    buf_state_t                 state_next;
    logic signed [SAMPLE_W-1:0] head;
    logic                       full;
    logic                       empty;
    logic                       pop;
    logic                       push;
    logic                       underrun_next;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (sample_in),
        .rd_en   (pop),
        .rd_data (head),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    assign sample_ready = (fifo_level != LW'(DEPTH));

    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        underrun_next = 1'b0;
        case (state)
            BUF_PRIME: begin
                if (fifo_level >= LW'(PRIME_LEVEL)) begin
                    state_next = BUF_RUN;
                end
            end
            BUF_RUN: begin
                if (new_frame) begin
                    if (empty) begin
                        underrun_next = 1'b1;
                        state_next    = BUF_PRIME;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: state_next = BUF_PRIME;
        endcase
        // A simultaneous pop frees a slot, so a full FIFO may still take the push.
        push = sample_valid && (!full || pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BUF_PRIME;
            pcm_out        <= '0;
            underrun       <= 1'b0;
            overflow       <= 1'b0;
            underrun_count <= '0;
        end else begin
            state    <= state_next;
            underrun <= underrun_next;
            overflow <= sample_valid && !push;
            if (new_frame) begin
                pcm_out <= pop ? scale_sample(head, vol_shift, mute) : '0;
            end
            if (underrun_next && (underrun_count != {CNT_W{1'b1}})) begin
                underrun_count <= underrun_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// tb/tb_pcm_sample_buffer.sv - directed self-checking bench for pcm_sample_buffer
module tb_pcm_sample_buffer;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic        sample_ready;
    logic        new_frame = 1'b0;
    logic        mute = 1'b0;
    logic [2:0]  vol_shift = '0;
    logic signed [15:0] pcm_out;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic        overflow;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;

    pcm_sample_buffer #(.DEPTH(16), .PRIME_LEVEL(8), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_in      (sample_in),
        .sample_ready   (sample_ready),
        .new_frame      (new_frame),
        .mute           (mute),
        .vol_shift      (vol_shift),
        .pcm_out        (pcm_out),
        .fifo_level     (fifo_level),
        .underrun       (underrun),
        .overflow       (overflow),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        sample_valid = 1'b1;
        sample_in    = 16'(v);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic frame();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_pcm", int'(pcm_out), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ready", int'(sample_ready), 1);
        check("rst_underrun", int'(underrun), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_count", int'(underrun_count), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: idle frames while priming
        for (int i = 0; i < 20; i++) begin
            frame();
            check("idle_pcm", int'(pcm_out), 0);
            check("idle_underrun", int'(underrun), 0);
        end
        check("idle_state", int'(dut.state), int'(BUF_PRIME));

        // 2: prime with 100..800 and play back
        for (int i = 1; i <= 8; i++) push(i * 100);
        check("prime_level", int'(fifo_level), 8);
        tick();
        check("run_state", int'(dut.state), int'(BUF_RUN));
        for (int i = 1; i <= 8; i++) begin
            new_frame = 1'b1;
            #3;
            check("pre_edge_hold", int'(pcm_out), (i == 1) ? 0 : (i - 1) * 100);
            @(posedge clk);
            #1;
            new_frame = 1'b0;
            check("play_pcm", int'(pcm_out), i * 100);
        end
        tick();
        check("play_hold", int'(pcm_out), 800);
        check("play_level", int'(fifo_level), 0);

        // 3: underrun on empty FIFO
        frame();
        check("ur_pcm", int'(pcm_out), 0);
        check("ur_pulse", int'(underrun), 1);
        check("ur_count", int'(underrun_count), 1);
        check("ur_state", int'(dut.state), int'(BUF_PRIME));
        tick();
        check("ur_pulse_end", int'(underrun), 0);

        // 4: overfill with 17 samples
        for (int i = 1; i <= 17; i++) begin
            push(i);
            check("ovf_pulse", int'(overflow), (i == 17) ? 1 : 0);
        end
        check("full_level", int'(fifo_level), 16);
        check("full_ready", int'(sample_ready), 0);
        tick();
        check("ovf_pulse_end", int'(overflow), 0);
        for (int i = 1; i <= 16; i++) begin
            frame();
            check("drain_pcm", int'(pcm_out), i);
        end
        check("drain_ready", int'(sample_ready), 1);
        // underrun with a simultaneous push: push is stored, no bypass
        sample_valid = 1'b1;
        sample_in    = -16'sd1024;
        frame();
        sample_valid = 1'b0;
        check("ur2_pcm", int'(pcm_out), 0);
        check("ur2_pulse", int'(underrun), 1);
        check("ur2_count", int'(underrun_count), 2);
        check("ur2_level", int'(fifo_level), 1);

        // 5: volume shift and mute
        push(-1024);
        for (int i = 0; i < 6; i++) push(5);
        check("p5_level", int'(fifo_level), 8);
        tick();
        vol_shift = 3'd3;
        frame();
        check("vol_pcm", int'($signed(pcm_out)), -128);
        check("vol_level", int'(fifo_level), 7);
        vol_shift = 3'd0;
        mute      = 1'b1;
        tick();
        check("vol_hold", int'($signed(pcm_out)), -128);
        vol_shift = 3'd3;
        frame();
        mute = 1'b0;
        check("mute_pcm", int'(pcm_out), 0);
        check("mute_level", int'(fifo_level), 6);

        // 6: push + pop on full FIFO, then reset mid-stream
        vol_shift = 3'd0;
        for (int i = 0; i < 10; i++) push(50 + i);
        check("f6_level", int'(fifo_level), 16);
        check("f6_ready", int'(sample_ready), 0);
        sample_valid = 1'b1;
        sample_in    = 16'sd77;
        frame();
        sample_valid = 1'b0;
        check("pp_pcm", int'(pcm_out), 5);
        check("pp_level", int'(fifo_level), 16);
        check("pp_overflow", int'(overflow), 0);
        reset = 1'b1;
        #1;
        check("mid_rst_level", int'(fifo_level), 0);
        check("mid_rst_pcm", int'(pcm_out), 0);
        check("mid_rst_ready", int'(sample_ready), 1);
        check("mid_rst_count", int'(underrun_count), 0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_state", int'(dut.state), int'(BUF_PRIME));
        frame();
        check("post_rst_underrun", int'(underrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
